// File: rtl/n37_sys_6x6.sv
// n37_sys_6x6: 36-lane AN-code (A=37) decoder with single-bit error correction.
// Stage 1 splits each codeword into quotient/residue by Barrett reduction;
// stage 2 applies the residue-indexed correction and clamps to 13 bits.
module n37_sys_6x6 (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] IN0,
  input  logic [17:0] IN1,
  input  logic [17:0] IN2,
  input  logic [17:0] IN3,
  input  logic [17:0] IN4,
  input  logic [17:0] IN5,
  input  logic [17:0] IN6,
  input  logic [17:0] IN7,
  input  logic [17:0] IN8,
  input  logic [17:0] IN9,
  input  logic [17:0] IN10,
  input  logic [17:0] IN11,
  input  logic [17:0] IN12,
  input  logic [17:0] IN13,
  input  logic [17:0] IN14,
  input  logic [17:0] IN15,
  input  logic [17:0] IN16,
  input  logic [17:0] IN17,
  input  logic [17:0] IN18,
  input  logic [17:0] IN19,
  input  logic [17:0] IN20,
  input  logic [17:0] IN21,
  input  logic [17:0] IN22,
  input  logic [17:0] IN23,
  input  logic [17:0] IN24,
  input  logic [17:0] IN25,
  input  logic [17:0] IN26,
  input  logic [17:0] IN27,
  input  logic [17:0] IN28,
  input  logic [17:0] IN29,
  input  logic [17:0] IN30,
  input  logic [17:0] IN31,
  input  logic [17:0] IN32,
  input  logic [17:0] IN33,
  input  logic [17:0] IN34,
  input  logic [17:0] IN35,
  output logic [12:0] OUT0,
  output logic [12:0] OUT1,
  output logic [12:0] OUT2,
  output logic [12:0] OUT3,
  output logic [12:0] OUT4,
  output logic [12:0] OUT5,
  output logic [12:0] OUT6,
  output logic [12:0] OUT7,
  output logic [12:0] OUT8,
  output logic [12:0] OUT9,
  output logic [12:0] OUT10,
  output logic [12:0] OUT11,
  output logic [12:0] OUT12,
  output logic [12:0] OUT13,
  output logic [12:0] OUT14,
  output logic [12:0] OUT15,
  output logic [12:0] OUT16,
  output logic [12:0] OUT17,
  output logic [12:0] OUT18,
  output logic [12:0] OUT19,
  output logic [12:0] OUT20,
  output logic [12:0] OUT21,
  output logic [12:0] OUT22,
  output logic [12:0] OUT23,
  output logic [12:0] OUT24,
  output logic [12:0] OUT25,
  output logic [12:0] OUT26,
  output logic [12:0] OUT27,
  output logic [12:0] OUT28,
  output logic [12:0] OUT29,
  output logic [12:0] OUT30,
  output logic [12:0] OUT31,
  output logic [12:0] OUT32,
  output logic [12:0] OUT33,
  output logic [12:0] OUT34,
  output logic [12:0] OUT35
);

  localparam int unsigned A       = 37;
  localparam int unsigned N_LANES = 36;
  localparam int unsigned IN_W    = 18;
  localparam int unsigned OUT_W   = 13;
  localparam int unsigned BK      = 24;
  localparam logic [37:0] BM      = 38'd453438;

  // Correction table, 64 slots of 15-bit signed so any 6-bit residue indexes safely.
  // Slot r holds (r - e)/A where e = +/-2^i is the single-bit error with e == r mod A.
  function automatic logic [64*15-1:0] f_delta_tab();
    logic [64*15-1:0] tab;
    int               p;
    int               pm;
    int               d;
    tab = '0;
    for (int unsigned r = 1; r < A; r++) begin
      for (int unsigned i = 0; i < IN_W; i++) begin
        p  = 1 << i;
        pm = p % int'(A);
        if (pm == int'(r)) begin
          d = (int'(r) - p) / int'(A);
          tab[r*15 +: 15] = d[14:0];
        end else if ((int'(A) - pm) == int'(r)) begin
          d = (int'(r) + p) / int'(A);
          tab[r*15 +: 15] = d[14:0];
        end
      end
    end
    return tab;
  endfunction

  localparam logic [64*15-1:0] DELTA_TAB = f_delta_tab();

  logic [IN_W-1:0]  w_in  [N_LANES];
  logic [OUT_W-1:0] r_out [N_LANES];

  assign w_in[0]  = IN0;   assign w_in[1]  = IN1;   assign w_in[2]  = IN2;
  assign w_in[3]  = IN3;   assign w_in[4]  = IN4;   assign w_in[5]  = IN5;
  assign w_in[6]  = IN6;   assign w_in[7]  = IN7;   assign w_in[8]  = IN8;
  assign w_in[9]  = IN9;   assign w_in[10] = IN10;  assign w_in[11] = IN11;
  assign w_in[12] = IN12;  assign w_in[13] = IN13;  assign w_in[14] = IN14;
  assign w_in[15] = IN15;  assign w_in[16] = IN16;  assign w_in[17] = IN17;
  assign w_in[18] = IN18;  assign w_in[19] = IN19;  assign w_in[20] = IN20;
  assign w_in[21] = IN21;  assign w_in[22] = IN22;  assign w_in[23] = IN23;
  assign w_in[24] = IN24;  assign w_in[25] = IN25;  assign w_in[26] = IN26;
  assign w_in[27] = IN27;  assign w_in[28] = IN28;  assign w_in[29] = IN29;
  assign w_in[30] = IN30;  assign w_in[31] = IN31;  assign w_in[32] = IN32;
  assign w_in[33] = IN33;  assign w_in[34] = IN34;  assign w_in[35] = IN35;

  assign OUT0  = r_out[0];   assign OUT1  = r_out[1];   assign OUT2  = r_out[2];
  assign OUT3  = r_out[3];   assign OUT4  = r_out[4];   assign OUT5  = r_out[5];
  assign OUT6  = r_out[6];   assign OUT7  = r_out[7];   assign OUT8  = r_out[8];
  assign OUT9  = r_out[9];   assign OUT10 = r_out[10];  assign OUT11 = r_out[11];
  assign OUT12 = r_out[12];  assign OUT13 = r_out[13];  assign OUT14 = r_out[14];
  assign OUT15 = r_out[15];  assign OUT16 = r_out[16];  assign OUT17 = r_out[17];
  assign OUT18 = r_out[18];  assign OUT19 = r_out[19];  assign OUT20 = r_out[20];
  assign OUT21 = r_out[21];  assign OUT22 = r_out[22];  assign OUT23 = r_out[23];
  assign OUT24 = r_out[24];  assign OUT25 = r_out[25];  assign OUT26 = r_out[26];
  assign OUT27 = r_out[27];  assign OUT28 = r_out[28];  assign OUT29 = r_out[29];
  assign OUT30 = r_out[30];  assign OUT31 = r_out[31];  assign OUT32 = r_out[32];
  assign OUT33 = r_out[33];  assign OUT34 = r_out[34];  assign OUT35 = r_out[35];

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    logic [37:0]       w_prod;
    logic [OUT_W-1:0]  w_qe;
    logic [6:0]        w_r0;
    logic [OUT_W-1:0]  w_q;
    logic [5:0]        w_r;
    logic [OUT_W-1:0]  r_q;
    logic [5:0]        r_r;
    logic [9:0]        w_idx;
    logic signed [14:0] w_delta;
    logic signed [14:0] w_n;
    logic [OUT_W-1:0]  w_sat;

    // Barrett estimate; qe may be one short, which the r0 >= A test repairs.
    always_comb begin
      w_prod = 38'(w_in[g]) * BM;
      w_qe   = OUT_W'(w_prod >> BK);
      w_r0   = 7'(w_in[g] - 18'(w_qe * 18'(A)));
      w_q    = w_qe;
      w_r    = 6'(w_r0);
      if (w_r0 >= 7'(A)) begin
        w_q = w_qe + 13'd1;
        w_r = 6'(w_r0 - 7'(A));
      end
    end

    // Stage-1 register: quotient and residue.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
        r_r <= '0;
      end else begin
        r_q <= w_q;
        r_r <= w_r;
      end
    end

    // Residue-indexed correction, then clamp into the 13-bit data range.
    always_comb begin
      w_idx   = 10'(r_r) * 10'd15;
      w_delta = $signed(DELTA_TAB[w_idx +: 15]);
      w_n     = $signed({2'b00, r_q}) + w_delta;
      w_sat   = w_n[12:0];
      if (w_n[14]) begin
        w_sat = '0;
      end else if (w_n > 15'sd8191) begin
        w_sat = '1;
      end
    end

    // Stage-2 register: decoded output.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out[g] <= '0;
      end else begin
        r_out[g] <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_n37_sys_6x6.sv
// Self-checking bench for n37_sys_6x6: directed corners, full-range streams,
// exhaustive single-bit error injection, random words, and mid-stream reset.
module tb_n37_sys_6x6;

  logic        clk;
  logic        rst;
  logic [17:0] in_v  [36];
  logic [12:0] out_v [36];

  int unsigned n_checks;
  int unsigned n_errors;

  n37_sys_6x6 dut (
    .clk(clk), .rst(rst),
    .IN0(in_v[0]),   .IN1(in_v[1]),   .IN2(in_v[2]),   .IN3(in_v[3]),
    .IN4(in_v[4]),   .IN5(in_v[5]),   .IN6(in_v[6]),   .IN7(in_v[7]),
    .IN8(in_v[8]),   .IN9(in_v[9]),   .IN10(in_v[10]), .IN11(in_v[11]),
    .IN12(in_v[12]), .IN13(in_v[13]), .IN14(in_v[14]), .IN15(in_v[15]),
    .IN16(in_v[16]), .IN17(in_v[17]), .IN18(in_v[18]), .IN19(in_v[19]),
    .IN20(in_v[20]), .IN21(in_v[21]), .IN22(in_v[22]), .IN23(in_v[23]),
    .IN24(in_v[24]), .IN25(in_v[25]), .IN26(in_v[26]), .IN27(in_v[27]),
    .IN28(in_v[28]), .IN29(in_v[29]), .IN30(in_v[30]), .IN31(in_v[31]),
    .IN32(in_v[32]), .IN33(in_v[33]), .IN34(in_v[34]), .IN35(in_v[35]),
    .OUT0(out_v[0]),   .OUT1(out_v[1]),   .OUT2(out_v[2]),   .OUT3(out_v[3]),
    .OUT4(out_v[4]),   .OUT5(out_v[5]),   .OUT6(out_v[6]),   .OUT7(out_v[7]),
    .OUT8(out_v[8]),   .OUT9(out_v[9]),   .OUT10(out_v[10]), .OUT11(out_v[11]),
    .OUT12(out_v[12]), .OUT13(out_v[13]), .OUT14(out_v[14]), .OUT15(out_v[15]),
    .OUT16(out_v[16]), .OUT17(out_v[17]), .OUT18(out_v[18]), .OUT19(out_v[19]),
    .OUT20(out_v[20]), .OUT21(out_v[21]), .OUT22(out_v[22]), .OUT23(out_v[23]),
    .OUT24(out_v[24]), .OUT25(out_v[25]), .OUT26(out_v[26]), .OUT27(out_v[27]),
    .OUT28(out_v[28]), .OUT29(out_v[29]), .OUT30(out_v[30]), .OUT31(out_v[31]),
    .OUT32(out_v[32]), .OUT33(out_v[33]), .OUT34(out_v[34]), .OUT35(out_v[35])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decoder: find the codeword nearest x by a single +/-2^i step, then clamp.
  function automatic int ref_decode(int x);
    int n;
    int p;
    n = 0;
    if (x % 37 == 0) begin
      n = x / 37;
    end else begin
      for (int i = 0; i < 18; i++) begin
        p = 1 << i;
        if ((x - p) % 37 == 0) n = (x - p) / 37;
        if ((x + p) % 37 == 0) n = (x + p) / 37;
      end
    end
    if (n < 0) n = 0;
    if (n > 8191) n = 8191;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int l = 0; l < 36; l++) in_v[l] = 18'($urandom_range(0, 262143));
    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < 36; l++) begin
      n_checks++;
      if (out_v[l] !== 13'd0) begin
        n_errors++;
        $display("FAIL reset lane %0d: got %0d expected 0", l, out_v[l]);
      end
    end
  endtask

  task automatic test_directed();
    int exp_v [36];
    rst = 1'b0;
    for (int l = 0; l < 36; l++) begin
      in_v[l]  = 18'($urandom_range(0, 262143));
      exp_v[l] = ref_decode(int'(in_v[l]));
    end
    in_v[0] = 18'd3700;   exp_v[0] = 100;
    in_v[1] = 18'd3668;   exp_v[1] = 100;
    in_v[2] = 18'd36;     exp_v[2] = 1;
    in_v[3] = 18'd262143; exp_v[3] = 7085;
    in_v[4] = 18'd1;      exp_v[4] = 0;
    in_v[5] = 18'd0;      exp_v[5] = 0;
    in_v[6] = 18'd18;     exp_v[6] = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < 36; l++) begin
      n_checks++;
      if (out_v[l] !== 13'(exp_v[l])) begin
        n_errors++;
        $display("FAIL directed lane %0d: got %0d expected %0d", l, out_v[l], exp_v[l]);
      end
    end
  endtask

  task automatic test_stream();
    int exp_cur [36];
    int exp_prev [36];
    bit have_prev;
    int k_l;
    have_prev = 1'b0;
    for (int k = 0; k <= 7085; k++) begin
      if (k < 7085) begin
        for (int l = 0; l < 36; l++) begin
          k_l = (k + 197 * l) % 7085;
          in_v[l]    = 18'(37 * k_l);
          exp_cur[l] = k_l;
        end
      end
      @(posedge clk);
      #1;
      if (have_prev) begin
        for (int l = 0; l < 36; l++) begin
          n_checks++;
          if (out_v[l] !== 13'(exp_prev[l])) begin
            n_errors++;
            $display("FAIL stream lane %0d step %0d: got %0d expected %0d",
                     l, k, out_v[l], exp_prev[l]);
          end
        end
      end
      exp_prev  = exp_cur;
      have_prev = 1'b1;
    end
  endtask

  task automatic test_single_errors();
    int exp_cur [36];
    int exp_prev [36];
    bit have_prev;
    int x;
    int e;
    have_prev = 1'b0;
    for (int n = 0; n <= 7085; n++) begin
      if (n < 7085) begin
        for (int l = 0; l < 36; l++) begin
          e = (l < 18) ? (1 << l) : -(1 << (l - 18));
          x = 37 * n + e;
          if (x < 0 || x > 262143) x = 37 * n;
          in_v[l]    = 18'(x);
          exp_cur[l] = n;
        end
      end
      @(posedge clk);
      #1;
      if (have_prev) begin
        for (int l = 0; l < 36; l++) begin
          n_checks++;
          if (out_v[l] !== 13'(exp_prev[l])) begin
            n_errors++;
            $display("FAIL single_err lane %0d N %0d: got %0d expected %0d",
                     l, n - 1, out_v[l], exp_prev[l]);
          end
        end
      end
      exp_prev  = exp_cur;
      have_prev = 1'b1;
    end
  endtask

  task automatic test_random();
    int exp_cur [36];
    int exp_prev [36];
    bit have_prev;
    int x;
    have_prev = 1'b0;
    for (int c = 0; c <= 400; c++) begin
      if (c < 400) begin
        for (int l = 0; l < 36; l++) begin
          if ($urandom_range(0, 3) == 0) x = 37 * int'($urandom_range(0, 7084));
          else                           x = int'($urandom_range(0, 262143));
          in_v[l]    = 18'(x);
          exp_cur[l] = ref_decode(x);
        end
      end
      @(posedge clk);
      #1;
      if (have_prev) begin
        for (int l = 0; l < 36; l++) begin
          n_checks++;
          if (out_v[l] !== 13'(exp_prev[l])) begin
            n_errors++;
            $display("FAIL random lane %0d in %0d: got %0d expected %0d",
                     l, c, out_v[l], exp_prev[l]);
          end
        end
      end
      exp_prev  = exp_cur;
      have_prev = 1'b1;
    end
  endtask

  task automatic test_midstream_reset();
    int exp_v [36];
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < 36; l++) in_v[l] = 18'(37 * int'($urandom_range(1, 7084)));
      @(posedge clk);
      #1;
    end
    #3 rst = 1'b1;
    #1;
    for (int l = 0; l < 36; l++) begin
      n_checks++;
      if (out_v[l] !== 13'd0) begin
        n_errors++;
        $display("FAIL async_reset lane %0d: got %0d expected 0", l, out_v[l]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int l = 0; l < 36; l++) begin
      in_v[l]  = 18'(37 * int'($urandom_range(1, 7084)));
      exp_v[l] = int'(in_v[l]) / 37;
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < 36; l++) begin
      n_checks++;
      if (out_v[l] !== 13'd0) begin
        n_errors++;
        $display("FAIL post_reset_1 lane %0d: got %0d expected 0", l, out_v[l]);
      end
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < 36; l++) begin
      n_checks++;
      if (out_v[l] !== 13'(exp_v[l])) begin
        n_errors++;
        $display("FAIL post_reset_2 lane %0d: got %0d expected %0d", l, out_v[l], exp_v[l]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    for (int l = 0; l < 36; l++) in_v[l] = '0;
    test_reset();
    test_directed();
    test_stream();
    test_single_errors();
    test_random();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
